// File: rtl/rom_note_player.sv
// Note sequencer: steps a 1-cycle synchronous ROM, plays each word as a square-wave divisor.
// Define NOTE_GAP_EN to insert a silent GAP-cycle pause after every note.
module rom_note_player #(
    parameter int AW  = 5,
    parameter int DW  = 16,
    parameter int DUR = 3_000_000,
    parameter int GAP = 300_000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] data,
    output logic [AW-1:0] addr,
    output logic          ch_out,
    output logic          busy,
    output logic          wrap
);

    localparam int DCW = $clog2(DUR + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_PLAY
`ifdef NOTE_GAP_EN
        , ST_GAP
`endif
    } state_t;

    state_t         state;
    state_t         state_d;
    logic [DW-1:0]  div_q;
    logic [DW-1:0]  tone_cnt;
    logic [DCW-1:0] dur_cnt;
    logic           play_last;

    assign play_last = (state == ST_PLAY) && (dur_cnt == DCW'(DUR - 1));
    assign busy      = (state != ST_IDLE);

`ifdef NOTE_GAP_EN
    localparam int GCW = $clog2(GAP + 1);

    logic [GCW-1:0] gap_cnt;
    logic           gap_last;

    assign gap_last = (state == ST_GAP) && (gap_cnt == GCW'(GAP - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (play_last) begin
            gap_cnt <= '0;
        end else if (state == ST_GAP) begin
            gap_cnt <= gap_cnt + GCW'(1);
        end
    end
`else
    // GAP has no effect without the gap state.
    logic unused_gap;
    assign unused_gap = (GAP < 1);
`endif

    // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:  if (en) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_PLAY;
            ST_PLAY: begin
                if (play_last) begin
`ifdef NOTE_GAP_EN
                    state_d = ST_GAP;
`else
                    state_d = ST_FETCH;
`endif
                end
            end
`ifdef NOTE_GAP_EN
            ST_GAP:   if (gap_last) state_d = ST_FETCH;
`endif
            default:  state_d = ST_IDLE;
        endcase
        // Stopping wins over every transition, including the end of a note.
        if (!en) state_d = ST_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr     <= '0;
            ch_out   <= 1'b0;
            wrap     <= 1'b0;
            div_q    <= '0;
            tone_cnt <= '0;
            dur_cnt  <= '0;
        end else begin
            wrap <= 1'b0;
            if (!en) begin
                // Interrupted note keeps addr so it restarts from FETCH on resume.
                ch_out <= 1'b0;
            end else begin
                case (state)
                    ST_LOAD: begin
                        div_q    <= data;
                        tone_cnt <= '0;
                        dur_cnt  <= '0;
                        ch_out   <= 1'b0;
                    end
                    ST_PLAY: begin
                        if (play_last) begin
                            ch_out  <= 1'b0;
                            dur_cnt <= '0;
                            addr    <= addr + AW'(1);
                            wrap    <= (addr == {AW{1'b1}});
                        end else begin
                            dur_cnt <= dur_cnt + DCW'(1);
                            if (div_q != '0) begin
                                if (tone_cnt == div_q - DW'(1)) begin
                                    ch_out   <= ~ch_out;
                                    tone_cnt <= '0;
                                end else begin
                                    tone_cnt <= tone_cnt + DW'(1);
                                end
                            end
                        end
                    end
                    default: ch_out <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_note_player.sv
// Self-checking bench for rom_note_player with a 4-word registered ROM holding {2,0,3,1}.
// Expected outputs come from hand-written vectors and a cycle-position model of the tune.
module tb_rom_note_player;

    localparam int AW  = 2;
    localparam int DW  = 4;
    localparam int DUR = 20;
    localparam int GAP = 5;
`ifdef NOTE_GAP_EN
    localparam int GAPC = GAP;
`else
    localparam int GAPC = 0;
`endif
    localparam int P   = DUR + 2 + GAPC;   // note-start spacing
    localparam int ADV = DUR + 3;          // edge (counted from en) after which addr first steps

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic [DW-1:0] data = '0;
    logic [AW-1:0] addr;
    logic          ch_out;
    logic          busy;
    logic          wrap;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          ch;
        logic          busy;
        logic          wrap;
    } exp_t;

    typedef struct {
        logic rst;
        logic en;
        int   adv;
        exp_t exp;
    } vec_t;

    rom_note_player #(
        .AW (AW),
        .DW (DW),
        .DUR(DUR),
        .GAP(GAP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .data  (data),
        .addr  (addr),
        .ch_out(ch_out),
        .busy  (busy),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_at(logic [AW-1:0] a);
        case (a)
            2'd0:    return 4'd2;
            2'd1:    return 4'd0;
            2'd2:    return 4'd3;
            default: return 4'd1;
        endcase
    endfunction

    always @(posedge clk) data <= rom_at(addr);

    // Outputs after edge e (e=1 is the first edge with en=1 from IDLE), tune starting at base.
    function automatic exp_t model(int e, int base);
        exp_t m;
        int cnt, n, ph, j, d;
        m = '0;
        cnt = (e >= ADV) ? (e - ADV) / P + 1 : 0;
        m.addr = AW'((base + cnt) % 4);
        m.busy = (e >= 1);
        m.wrap = (e >= ADV) && ((e - ADV) % P == 0) && ((base + cnt) % 4 == 0);
        if (e >= 1) begin
            n  = (e - 1) / P;
            ph = (e - 1) % P;
            if (ph >= 2 && ph <= DUR + 1) begin
                d = int'(rom_at(AW'((base + n) % 4)));
                j = ph - 2;
                if (d != 0) m.ch = ((j / d) % 2) == 1;
            end
        end
        return m;
    endfunction

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [7:0] act, logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_all(string tag, exp_t m);
        check({tag, " addr"}, 8'(addr), 8'(m.addr));
        check({tag, " ch_out"}, 8'(ch_out), 8'(m.ch));
        check({tag, " busy"}, 8'(busy), 8'(m.busy));
        check({tag, " wrap"}, 8'(wrap), 8'(m.wrap));
    endtask

    initial begin
        vec_t vecs[8];
        int   wraps;

        // {rst, en, edges to advance, {addr, ch_out, busy, wrap}}
        vecs[0] = '{1'b1, 1'b0, 2,  '{2'd0, 1'b0, 1'b0, 1'b0}};
        vecs[1] = '{1'b0, 1'b0, 3,  '{2'd0, 1'b0, 1'b0, 1'b0}};
        vecs[2] = '{1'b0, 1'b1, 1,  '{2'd0, 1'b0, 1'b1, 1'b0}};
        vecs[3] = '{1'b0, 1'b1, 4,  '{2'd0, 1'b1, 1'b1, 1'b0}};
        vecs[4] = '{1'b0, 1'b1, 2,  '{2'd0, 1'b0, 1'b1, 1'b0}};
        vecs[5] = '{1'b0, 1'b1, 1,  '{2'd0, 1'b0, 1'b1, 1'b0}};
        vecs[6] = '{1'b0, 1'b1, 1,  '{2'd0, 1'b1, 1'b1, 1'b0}};
        vecs[7] = '{1'b0, 1'b1, 14, '{2'd1, 1'b0, 1'b1, 1'b0}};

        for (int i = 0; i < 8; i++) begin
            rst = vecs[i].rst;
            en  = vecs[i].en;
            step(vecs[i].adv);
            check_all($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Continue the same run: remaining notes, wrap, and a full replay of note 0.
        wraps = 0;
        for (int e = ADV + 1; e <= ADV + 4 * P; e++) begin
            step(1);
            check_all($sformatf("run e=%0d", e), model(e, 0));
            if (wrap === 1'b1) wraps++;
        end
        check("wrap_pulses", 8'(wraps), 8'd1);

        // Stop in PLAY cycle 10 of note 2, hold, then resume and replay note 2 in full.
        rst = 1'b1;
        en  = 1'b0;
        step(1);
        rst = 1'b0;
        en  = 1'b1;
        step(2 * P + 13);
        check_all("pre_stop", model(2 * P + 13, 0));
        en = 1'b0;
        step(1);
        check_all("stopped", '{2'd2, 1'b0, 1'b0, 1'b0});
        step(3);
        check_all("held", '{2'd2, 1'b0, 1'b0, 1'b0});
        en = 1'b1;
        for (int r = 1; r <= P + 8; r++) begin
            step(1);
            check_all($sformatf("resume r=%0d", r), model(r, 2));
        end

        // Reset in the middle of note 3 with en still high, then restart from note 0.
        rst = 1'b1;
        step(1);
        check_all("mid_rst", '{2'd0, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;
        for (int e = 1; e <= P + ADV; e++) begin
            step(1);
            check_all($sformatf("restart e=%0d", e), model(e, 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
